// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencing controller for the 8-bit matrix-multiply datapath.
// Loads A and B from a byte stream, runs the MAC schedule one C element at a
// time (CLR, N x MAC, DRAIN, WR), then streams each 18-bit result as 3 bytes.
// Optional build macro MATMUL_CYCLE_CNT_EN adds a saturating busy-cycle counter.
module matmul_ctrl #(
    parameter int N             = 4,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     m1EN,
    output logic                     m1rEN,
    output logic                     m1wEN,
    output logic                     m2EN,
    output logic                     m2rEN,
    output logic                     m2wEN,
    output logic                     m3EN,
    output logic                     m3rEN,
    output logic                     m3wEN,
    output logic                     mult_ld,
    output logic                     mult_rst,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic [ADDRESS_WIDTH-1:0] addr3,
`ifdef MATMUL_CYCLE_CNT_EN
    output logic [15:0]              cycle_cnt,
`endif
    output logic [1:0]               shift_cnt
);

    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] NL   = AW'(N);
    localparam logic [AW-1:0] NM1  = AW'(N - 1);
    localparam logic [AW-1:0] LAST = AW'(N * N - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, CLR, MAC, DRAIN, WR, OUT_RD, OUT_SEND, DONE
    } state_t;

    state_t state, state_nx;
    logic [AW-1:0] i, j, k, e;
    logic [1:0]    s;
    logic          ld_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = LOAD_A;
            LOAD_A:   if (in_valid && e == LAST) state_nx = LOAD_B;
            LOAD_B:   if (in_valid && e == LAST) state_nx = CLR;
            CLR:      state_nx = MAC;
            MAC:      if (k == NM1) state_nx = DRAIN;
            DRAIN:    state_nx = WR;
            WR:       state_nx = (i == NM1 && j == NM1) ? OUT_RD : CLR;
            OUT_RD:   state_nx = OUT_SEND;
            OUT_SEND: if (out_ready && s == 2'd2) state_nx = (e == LAST) ? DONE : OUT_RD;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Loop counters: e = element/byte index, i/j = C coordinates, k = MAC step, s = byte select
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0; j <= '0; k <= '0; e <= '0; s <= '0;
        end else begin
            case (state)
                IDLE:   if (start) e <= '0;
                LOAD_A: if (in_valid) e <= (e == LAST) ? '0 : e + 1'b1;
                LOAD_B: if (in_valid) begin
                    e <= (e == LAST) ? '0 : e + 1'b1;
                    if (e == LAST) begin
                        i <= '0;
                        j <= '0;
                    end
                end
                CLR:    k <= '0;
                MAC:    k <= k + 1'b1;
                WR: begin
                    if (j == NM1) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (i == NM1 && j == NM1) e <= '0;
                end
                OUT_RD: s <= '0;
                OUT_SEND: if (out_ready) begin
                    if (s == 2'd2) begin
                        s <= '0;
                        e <= e + 1'b1;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lands one cycle after issue, so the accumulate strobe is the delayed read flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ld_q <= 1'b0;
        else      ld_q <= (state == MAC);
    end

    // Output decode from current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        m1rEN     = 1'b0; m1wEN = 1'b0;
        m2rEN     = 1'b0; m2wEN = 1'b0;
        m3rEN     = 1'b0; m3wEN = 1'b0;
        mult_rst  = 1'b0;
        addr1     = '0;
        addr2     = '0;
        addr3     = '0;
        shift_cnt = '0;
        case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin m1wEN = 1'b1; addr1 = e; end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin m2wEN = 1'b1; addr2 = e; end
            end
            CLR: mult_rst = 1'b1;
            MAC: begin
                m1rEN = 1'b1;
                m2rEN = 1'b1;
                addr1 = i * NL + k;
                addr2 = k * NL + j;
            end
            WR: begin
                m3wEN = 1'b1;
                addr3 = i * NL + j;
            end
            OUT_RD: begin
                m3rEN = 1'b1;
                addr3 = e;
            end
            OUT_SEND: begin
                // re-issuing the same read keeps the result word stable across stalls
                m3rEN     = 1'b1;
                addr3     = e;
                out_valid = 1'b1;
                shift_cnt = s;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign mult_ld = ld_q;
    assign m1EN    = m1rEN | m1wEN;
    assign m2EN    = m2rEN | m2wEN;
    assign m3EN    = m3rEN | m3wEN;

`ifdef MATMUL_CYCLE_CNT_EN
    // Busy-cycle counter: cleared when a start is taken, saturates, holds in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          cycle_cnt <= '0;
        else if (state == IDLE && start)   cycle_cnt <= '0;
        else if (busy && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: behavioural datapath (RAMs, accumulator, shifter)
// around the controller, expected bytes queued per operation and checked by
// an independent output monitor.
module tb_matmul_ctrl;

    localparam int N  = 4;
    localparam int AW = 6;

    logic clk = 0, rst = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [7:0] data_in = 0;
    logic in_ready, out_valid, busy, done;
    logic m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN;
    logic mult_ld, mult_rst;
    logic [AW-1:0] addr1, addr2, addr3;
    logic [1:0] shift_cnt;
`ifdef MATMUL_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    matmul_ctrl #(.N(N), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .m1EN(m1EN), .m1rEN(m1rEN), .m1wEN(m1wEN),
        .m2EN(m2EN), .m2rEN(m2rEN), .m2wEN(m2wEN),
        .m3EN(m3EN), .m3rEN(m3rEN), .m3wEN(m3wEN),
        .mult_ld(mult_ld), .mult_rst(mult_rst),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
`ifdef MATMUL_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .shift_cnt(shift_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural datapath ----------------
    logic [7:0]  memA [64];
    logic [7:0]  memB [64];
    logic [17:0] memC [64];
    logic [7:0]  rdA = 0, rdB = 0;
    logic [17:0] rdC = 0, acc = 0;
    logic [7:0]  data_out;

    always @(posedge clk) begin
        if (m1EN && m1wEN) memA[addr1] <= data_in;
        if (m1EN && m1rEN) rdA <= memA[addr1];
        if (m2EN && m2wEN) memB[addr2] <= data_in;
        if (m2EN && m2rEN) rdB <= memB[addr2];
        if (m3EN && m3wEN) memC[addr3] <= acc;
        if (m3EN && m3rEN) rdC <= memC[addr3];
        if (mult_rst)     acc <= 18'd0;
        else if (mult_ld) acc <= acc + ({10'd0, rdA} * {10'd0, rdB});
    end

    always_comb begin
        case (shift_cnt)
            2'd0:    data_out = rdC[7:0];
            2'd1:    data_out = rdC[15:8];
            default: data_out = {6'd0, rdC[17:16]};
        endcase
    end

    // ---------------- scoreboard / bookkeeping ----------------
    int tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mA [16];
    logic [7:0] mB [16];
    int out_mode = 0, ocyc = 0;
    int cyc = 0, nbytes = 0, ndone = 0, nin = 0, ncomp = 0, nbusy = 0;
    int last_in_cyc = -1, first_clr = -1;
    logic prev_stall = 0, done_prev = 0;
    logic [1:0] prev_sc = 0;
    logic [7:0] prev_byte = 0;
    logic [AW-1:0] prev_a3 = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // consumer back-pressure pattern
    always @(posedge clk) begin
        #1;
        if (out_mode == 0) out_ready = 1'b1;
        else               out_ready = (ocyc % 3 == 0);
        ocyc++;
    end

    // output monitor: pops and compares whenever a byte is accepted
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (prev_stall) begin
                chk("valid_held", int'(out_valid), 1);
                chk("stall_shift", int'(shift_cnt), int'(prev_sc));
                chk("stall_byte", int'(data_out), int'(prev_byte));
                chk("stall_addr3", int'(addr3), int'(prev_a3));
            end
            if (out_valid && out_ready) begin
                nbytes++;
                if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
                else chk("out_byte", int'(data_out), int'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_sc    = shift_cnt;
            prev_byte  = data_out;
            prev_a3    = addr3;
            if (done_prev) chk("busy_after_done", int'(busy), 0);
            done_prev = done;
            if (done) ndone++;
            if (busy) nbusy++;
            if (in_valid && in_ready) begin
                nin++;
                if (nin == 2 * N * N) last_in_cyc = cyc;
            end
            if (mult_rst && first_clr < 0) first_clr = cyc;
            if (busy && !in_ready && !m3rEN && !done) ncomp++;
        end else begin
            prev_stall = 0;
            done_prev  = 0;
        end
    end

    task automatic reset_stats();
        nbytes = 0; ndone = 0; nin = 0; ncomp = 0; nbusy = 0;
        last_in_cyc = -1; first_clr = -1;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int c;
        repeat (gap) begin
            in_valid = 0;
            @(posedge clk); #1;
        end
        in_valid = 1;
        data_in  = b;
        c = 0;
        while (!in_ready && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic load_mats(input int gapped);
        for (int x = 0; x < N * N; x++) send_byte(mA[x], gapped != 0 ? int'($urandom_range(0, 2)) : 0);
        for (int x = 0; x < N * N; x++) send_byte(mB[x], gapped != 0 ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic push_expected();
        logic [17:0] c;
        for (int r = 0; r < N; r++)
            for (int q = 0; q < N; q++) begin
                c = 0;
                for (int t = 0; t < N; t++) c = c + 18'(mA[r*N+t]) * 18'(mB[t*N+q]);
                exp_q.push_back(c[7:0]);
                exp_q.push_back(c[15:8]);
                exp_q.push_back({6'd0, c[17:16]});
            end
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 5000) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // full operation; exact = 1 when load and drain run at full rate
    task automatic run_op(input string tag, input int mode, input int gapped, input int exact);
        reset_stats();
        out_mode = mode;
        push_expected();
        do_start();
        load_mats(gapped);
        wait_done();
        chk({tag, "_bytes"}, nbytes, 3 * N * N);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_done_pulses"}, ndone, 1);
        chk({tag, "_compute_cycles"}, ncomp, N * N * (N + 3));
        chk({tag, "_clr_after_last_byte"}, first_clr - last_in_cyc, 1);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        if (exact != 0) begin
            chk({tag, "_busy_cycles"}, nbusy, 2 * N * N + N * N * (N + 3) + N * N * 4 + 1);
`ifdef MATMUL_CYCLE_CNT_EN
            chk({tag, "_cycle_cnt"}, int'(cycle_cnt), nbusy);
            repeat (5) @(posedge clk);
            #1 chk({tag, "_cycle_cnt_hold"}, int'(cycle_cnt), 209);
`endif
        end
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, int'({in_ready, out_valid, busy, done, m1EN, m1rEN, m1wEN,
                                 m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN, mult_ld, mult_rst}), 0);
        chk({tag, "_addr"}, int'({addr1, addr2, addr3, shift_cnt}), 0);
    endtask

    task automatic set_identity_a_seq_b();
        for (int x = 0; x < N * N; x++) begin
            mA[x] = (x / N == x % N) ? 8'd1 : 8'd0;
            mB[x] = 8'(x + 1);
        end
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 1;

        // T1: identity x (1..16), full-rate consumer
        set_identity_a_seq_b();
        run_op("t1_identity", 0, 0, 1);

        // T2: all 0xFF, every C = 0x3F804
        for (int x = 0; x < N * N; x++) begin mA[x] = 8'hFF; mB[x] = 8'hFF; end
        run_op("t2_ff", 0, 0, 1);

        // T3: all 2, consumer ready one cycle in three
        for (int x = 0; x < N * N; x++) begin mA[x] = 8'd2; mB[x] = 8'd2; end
        run_op("t3_stall", 1, 0, 0);

        // T4: gapped load, A[i][k] = i+k, B = identity
        for (int x = 0; x < N * N; x++) begin
            mA[x] = 8'(x / N + x % N);
            mB[x] = (x / N == x % N) ? 8'd1 : 8'd0;
        end
        run_op("t4_gapped", 0, 1, 0);

        // T5: start pulsed mid-MAC is ignored, then reset aborts mid-MAC
        reset_stats();
        out_mode = 0;
        set_identity_a_seq_b();
        do_start();
        load_mats(0);
        c = 0;
        while (!m1rEN && c < 100) begin @(posedge clk); #1; c++; end
        chk("t5_reach_mac", int'(m1rEN), 1);
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("t5_start_ignored_busy", int'(busy), 1);
        chk("t5_start_ignored_inready", int'(in_ready), 0);
        chk("t5_mac_addr1", int'(addr1), 2);
        chk("t5_mac_addr2", int'(addr2), 8);
        #2 rst = 0;
        #1 check_zero("t5_async_reset");
        @(posedge clk); #1;
        check_zero("t5_reset_held");
        rst = 1;
        run_op("t5_fresh", 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
